ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; clears all state immediately when low.
REQ-004 start  in  1  EX stage requests an operation this cycle; sampled only in IDLE.
REQ-005 op  in  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 opa  in  32  operand A (rs value / dividend).
REQ-007 opb  in  32  operand B (rt value / divisor).
REQ-008 flush  in  1  pipeline flush; aborts any operation in progress.
REQ-009 mthi  in  1  write wdata to HI (MTHI).
REQ-010 mtlo  in  1  write wdata to LO (MTLO).
REQ-011 wdata  in  32  data for mthi/mtlo.
REQ-012 busy  out  1  operation in progress; the pipeline stalls ID/EX while high; registered.
REQ-013 done  out  1  one-cycle pulse; hi/lo hold the new result in that cycle; registered.
REQ-014 hi  out  32  HI register (product[63:32] or remainder).
REQ-015 lo  out  32  LO register (product[31:0] or quotient).

Function
REQ-016 States: IDLE, RUN, FIX, DONE; encoding is free.
REQ-017 IDLE: start=1 and flush=0 at an edge -> RUN.
  - Operands and op are latched at that edge.
  - Signed ops latch the magnitudes and the result signs.
  - Iteration counter is cleared to 0.
REQ-018 RUN: one iteration per edge for exactly 32 edges, then -> FIX.
  - Multiply: shift-add.
  - Divide: restoring, one quotient bit per iteration.
REQ-019 FIX: one edge.
  - Negate the product when operand signs differ (MULT).
  - Negate the quotient when dividend and divisor signs differ (DIV).
  - Negate the remainder when the dividend is negative (DIV).
  - Load hi/lo; -> DONE.
REQ-020 DONE: done=1 for exactly one cycle; -> IDLE on the next edge.
REQ-021 Latency: start sampled at edge T0 -> busy=1 from T0 through T0+34; done=1 and new hi/lo valid in the cycle after edge T0+33; IDLE after edge T0+34. The latency is identical for all four ops and all operand values.
REQ-022 busy=1 in RUN, FIX and DONE; busy=0 in IDLE.
REQ-023 start is ignored while busy=1; no queuing.
REQ-024 Divide by zero (opb=0, DIV or DIVU): lo=32'hFFFFFFFF, hi=opa as latched. Full latency applies; no exception is raised.
REQ-025 DIV overflow (opa=32'h80000000, opb=32'hFFFFFFFF): lo=32'h80000000, hi=32'h0.
REQ-026 Results are exact modulo 2^64 (multiply) or truncated toward zero (divide); no saturation.
REQ-027 mthi/mtlo write hi/lo at the edge only when in IDLE and start=0; otherwise they are ignored.
REQ-028 mthi and mtlo asserted in the same cycle write both registers with wdata.
REQ-029 flush=1 at any edge -> IDLE.
  - hi/lo are unchanged and done is not asserted.
  - flush has priority over start, mthi and mtlo in the same cycle.
REQ-030 flush during DONE: hi/lo keep the already-loaded result; done drops next cycle.

Reset
REQ-031 While reset=0: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, and all internal operand/accumulator registers are 0.
REQ-032 Reset asserted mid-operation aborts immediately; no partial result reaches hi/lo.
REQ-033 After reset is deasserted, the first start is accepted at the first rising edge where it is sampled high.

Verification
REQ-034 MULT opa=-3 (32'hFFFFFFFD), opb=7 -> done at T0+34 cycle; hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; busy high for exactly 34 cycles.
REQ-035 MULTU opa=opb=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-036 DIV opa=-7, opb=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); DIVU opa=100, opb=0 -> lo=32'hFFFFFFFF, hi=100.
REQ-037 DIVU 100/7 started, flush at T0+10 -> busy=0 next cycle, no done pulse, hi/lo retain their prior values; a new start then completes normally with lo=14, hi=2.
REQ-038 A start held high through a full operation -> exactly one done pulse per accepted start. Back-to-back starts are spaced 35 cycles apart.
REQ-039 MTHI 32'hA5A5A5A5 in IDLE -> hi updated next edge. MTLO during busy -> lo unchanged. Reset low mid-RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// Bus between the EX stage and the iterative multiply/divide unit.
// master: EX stage drives requests, flush and MTHI/MTLO writes and reads status and HI/LO.
// slave:  the multiply/divide unit.
//   start       request an operation (taken only when the unit is idle)
//   op[1:0]     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   opa, opb    operand A (multiplicand / dividend), operand B (multiplier / divisor)
//   flush       abort any operation in progress
//   mthi, mtlo  write wdata into HI / LO
//   busy, done  operation in progress / one-cycle completion pulse
//   hi, lo      HI and LO architectural registers
interface ex_muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, opa, opb, flush, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, opa, opb, flush, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// Every operation takes a fixed 35 cycles: one accept edge, 32 iteration edges (shift-add
// multiply or restoring divide on operand magnitudes), one sign-fix edge that loads HI/LO,
// and one DONE cycle. MTHI/MTLO write HI/LO while idle. flush aborts without touching HI/LO.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    ex_muldiv_if slave modport (see interface header)
module ex_muldiv (
    input  logic       clock,
    input  logic       reset,
    ex_muldiv_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;   // negate product / quotient in FIX
    logic        neg_rem_q, neg_rem_d;   // negate remainder in FIX (dividend negative)
    logic [31:0] mcand_q, mcand_d;       // multiplicand magnitude or divisor magnitude
    logic [31:0] acc_q, acc_d;           // product upper half or partial remainder
    logic [31:0] low_q, low_d;           // multiplier/product lower half or dividend/quotient
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        op_signed;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ok;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        op_signed = ~bus.op[0];
        mag_a     = (op_signed && bus.opa[31]) ? (32'd0 - bus.opa) : bus.opa;
        mag_b     = (op_signed && bus.opb[31]) ? (32'd0 - bus.opb) : bus.opb;

        mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, mcand_q} : 33'd0);

        // Restoring step: no borrow out of the 33-bit subtract means the divisor fits.
        div_shift = {acc_q, low_q[31]};
        div_diff  = div_shift - {1'b0, mcand_q};
        div_ok    = ~div_diff[32];

        prod_fix  = neg_res_q ? (64'd0 - {acc_q, low_q}) : {acc_q, low_q};
        quo_fix   = neg_res_q ? (32'd0 - low_q) : low_q;
        rem_fix   = neg_rem_q ? (32'd0 - acc_q) : acc_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        low_d     = low_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StRun;
                    cnt_d     = 5'd0;
                    is_div_d  = bus.op[1];
                    neg_res_d = op_signed && (bus.opa[31] ^ bus.opb[31]);
                    neg_rem_d = op_signed && bus.opa[31];
                    acc_d     = 32'd0;
                    mcand_d   = bus.op[1] ? mag_b : mag_a;
                    low_d     = bus.op[1] ? mag_a : mag_b;
                end else begin
                    if (bus.mthi) hi_d = bus.wdata;
                    if (bus.mtlo) lo_d = bus.wdata;
                end
            end
            StRun: begin
                if (is_div_q) begin
                    acc_d = div_ok ? div_diff[31:0] : div_shift[31:0];
                    low_d = {low_q[30:0], div_ok};
                end else begin
                    {acc_d, low_d} = {mul_sum, low_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = StFix;
            end
            StFix: begin
                if (is_div_q) begin
                    // Divisor magnitude zero: quotient forced to all ones; the remainder
                    // path already reproduces the original dividend.
                    lo_d = (mcand_q == 32'd0) ? 32'hFFFF_FFFF : quo_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // flush wins over everything, including a start or MTHI/MTLO in the same cycle.
        if (bus.flush) begin
            state_d = StIdle;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mcand_q   <= 32'd0;
            acc_q     <= 32'd0;
            low_q     <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            low_q     <= low_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: a reference model computes {hi,lo} for every operation,
// pushes it onto a scoreboard queue at start, and the entry is popped when done pulses.
module tb_ex_muldiv;

    logic clock;
    logic reset;

    ex_muldiv_if bus ();

    ex_muldiv dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          vecs = 0;
    int          miscompares = 0;
    logic [63:0] sb[$];
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0]     ea, eb;
        int signed       sa, sb_v;
        logic [31:0]     q, r;
        case (op)
            2'b00: begin
                ea = {{32{a[31]}}, a};
                eb = {{32{b[31]}}, b};
                return ea * eb;
            end
            2'b01: begin
                ea = {32'd0, a};
                eb = {32'd0, b};
                return ea * eb;
            end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa   = a;
                sb_v = b;
                q    = sa / sb_v;
                r    = sa % sb_v;
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // One full operation; optionally pokes MTLO while busy and checks it is ignored.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit poke_mtlo);
        int          cyc;
        bit          busy_all;
        logic [63:0] exp;
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        sb.push_back(model(op, a, b));
        @(negedge clock);
        bus.start = 1'b0;
        cyc       = 0;
        busy_all  = 1'b1;
        while (bus.done !== 1'b1 && cyc < 50) begin
            busy_all &= (bus.busy === 1'b1);
            if (poke_mtlo && cyc == 3) begin
                bus.mtlo  = 1'b1;
                bus.wdata = 32'hDEAD_BEEF;
            end
            if (poke_mtlo && cyc == 4) begin
                bus.mtlo = 1'b0;
                chk({tag, " lo kept across busy mtlo"}, {32'd0, bus.lo}, {32'd0, last_lo});
            end
            @(negedge clock);
            cyc++;
        end
        busy_all &= (bus.busy === 1'b1);
        chk({tag, " done latency"}, 64'(cyc), 64'd33);
        chk({tag, " busy held 34 cycles"}, {63'd0, busy_all}, 64'd1);
        exp = (sb.size() != 0) ? sb.pop_front() : 64'hX;
        chk({tag, " hi:lo"}, {bus.hi, bus.lo}, exp);
        last_hi = exp[63:32];
        last_lo = exp[31:0];
        @(negedge clock);
        chk({tag, " busy drops"}, {63'd0, bus.busy}, 64'd0);
        chk({tag, " done one cycle"}, {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        int          n_done;
        int          first_at;
        int          second_at;
        logic [63:0] exp;
        logic [31:0] ra, rb;

        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.opa   = 32'd0;
        bus.opb   = 32'd0;
        bus.flush = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = 32'd0;
        last_hi   = 32'd0;
        last_lo   = 32'd0;

        repeat (3) @(negedge clock);
        chk("reset busy", {63'd0, bus.busy}, 64'd0);
        chk("reset done", {63'd0, bus.done}, 64'd0);
        chk("reset hi:lo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b1;

        // Verification examples and boundaries.
        do_op("MULT -3*7", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
        chk("MULT -3*7 const", {last_hi, last_lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        do_op("MULTU max*max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op("DIV -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op("DIVU 100/0", 2'b11, 32'd100, 32'd0, 1'b0);
        do_op("DIV -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0);
        do_op("DIV ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("MULT min*min", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op("DIV 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
        do_op("DIVU big", 2'b11, 32'hFFFF_FFFF, 32'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_op("random", 2'(i), ra, rb, 1'b0);
        end

        // MTHI in idle, then MTHI+MTLO together.
        @(negedge clock);
        bus.mthi  = 1'b1;
        bus.wdata = 32'hA5A5_A5A5;
        @(negedge clock);
        bus.mthi = 1'b0;
        chk("mthi hi", {bus.hi, bus.lo}, {32'hA5A5_A5A5, last_lo});
        last_hi   = 32'hA5A5_A5A5;
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h1234_5678;
        @(negedge clock);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        chk("mthi+mtlo", {bus.hi, bus.lo}, {32'h1234_5678, 32'h1234_5678});
        last_hi = 32'h1234_5678;
        last_lo = 32'h1234_5678;

        // flush beats start and mthi in the same cycle.
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.mthi  = 1'b1;
        bus.wdata = 32'hFFFF_0000;
        @(negedge clock);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        chk("flush prio busy", {63'd0, bus.busy}, 64'd0);
        chk("flush prio hi:lo", {bus.hi, bus.lo}, {last_hi, last_lo});

        // MTLO while busy is ignored.
        do_op("MULTU mtlo busy", 2'b01, 32'd6, 32'd9, 1'b1);

        // Flush at T0+10 of DIVU 100/7.
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.opa   = 32'd100;
        bus.opb   = 32'd7;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (9) @(negedge clock);
        bus.flush = 1'b1;
        @(negedge clock);
        bus.flush = 1'b0;
        chk("flush busy", {63'd0, bus.busy}, 64'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) n_done++;
            @(negedge clock);
        end
        chk("flush no done", 64'(n_done), 64'd0);
        chk("flush hi:lo kept", {bus.hi, bus.lo}, {last_hi, last_lo});
        do_op("DIVU 100/7", 2'b11, 32'd100, 32'd7, 1'b0);
        chk("DIVU 100/7 const", {last_hi, last_lo}, {32'd2, 32'd14});

        // start held high for 70 edges: exactly two accepted, dones 35 cycles apart.
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.opa   = 32'd3;
        bus.opb   = 32'd5;
        sb.push_back(model(2'b01, 32'd3, 32'd5));
        sb.push_back(model(2'b01, 32'd3, 32'd5));
        n_done    = 0;
        first_at  = -1;
        second_at = -1;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clock);
            if (bus.done === 1'b1) begin
                n_done++;
                if (first_at < 0) first_at = i;
                else second_at = i;
                exp = (sb.size() != 0) ? sb.pop_front() : 64'hX;
                chk("held start hi:lo", {bus.hi, bus.lo}, exp);
            end
        end
        bus.start = 1'b0;
        chk("held start dones", 64'(n_done), 64'd2);
        chk("held start spacing", 64'(second_at - first_at), 64'd35);
        @(negedge clock);
        @(negedge clock);
        chk("held start idle", {63'd0, bus.busy}, 64'd0);
        last_hi = 32'd0;
        last_lo = 32'd15;

        // Asynchronous reset mid-RUN.
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.opa   = 32'd11;
        bus.opb   = 32'd13;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (10) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("async rst busy", {63'd0, bus.busy}, 64'd0);
        chk("async rst done", {63'd0, bus.done}, 64'd0);
        chk("async rst hi:lo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clock);
        reset   = 1'b1;
        last_hi = 32'd0;
        last_lo = 32'd0;
        do_op("post-reset MULT", 2'b00, 32'hFFFF_FFF0, 32'd16, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
